// File: rtl/sccomp_debug_display.sv
// -----------------------------------------------------------------------------
// sccomp_debug_display
//
// Debug display controller for the single-cycle computer. Once per display
// frame it latches one 32-bit observation word and shows it as 8 hex digits on
// a common-anode seven-segment display, scanning one digit per slot.
//
// Parameters
//   SCAN_DIV     clock cycles per digit slot (>= 2)
//   AUTO_FRAMES  frames per register step in the auto-scan view (>= 1)
//
// Ports
//   clock     in   system clock, rising edge
//   reset     in   asynchronous, active-high reset
//   sel       in   [2:0] view: 0 pc, 1 inst, 2 aluout, 3 memout,
//                  4 register (manual), 5 register (auto-scan), 6/7 zero
//   btn_next  in   one-cycle pulse, advances the register index in view 4
//   pc        in   [31:0] program counter
//   inst      in   [31:0] current instruction
//   aluout    in   [31:0] ALU result
//   memout    in   [31:0] data-memory read value
//   reg_out   in   [31:0] register-file read data for reg_addr
//   reg_addr  out  [4:0]  register index for the computer's debug read port
//   an        out  [7:0]  digit enables, active-low, an[k] = digit k
//   seg       out  [7:0]  segments, active-low, seg[6:0] = g..a, seg[7] = dp
// -----------------------------------------------------------------------------
module sccomp_debug_display #(
  parameter int unsigned SCAN_DIV    = 50000,
  parameter int unsigned AUTO_FRAMES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  sel,
  input  logic        btn_next,
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  input  logic [31:0] aluout,
  input  logic [31:0] memout,
  input  logic [31:0] reg_out,
  output logic [4:0]  reg_addr,
  output logic [7:0]  an,
  output logic [7:0]  seg
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam logic [PW-1:0] PRE_LAST   = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(AUTO_FRAMES - 1);

  typedef enum logic [2:0] {
    VIEW_PC    = 3'd0,
    VIEW_INST  = 3'd1,
    VIEW_ALU   = 3'd2,
    VIEW_MEM   = 3'd3,
    VIEW_REG   = 3'd4,
    VIEW_AUTO  = 3'd5,
    VIEW_ZERO0 = 3'd6,
    VIEW_ZERO1 = 3'd7
  } view_t;

  view_t view;
  assign view = view_t'(sel);

  // ---------------------------------------------------------------------------
  // Digit-slot prescaler and digit index
  // ---------------------------------------------------------------------------
  logic [PW-1:0] pre;
  logic [2:0]    dig;
  logic          tick;
  logic          boundary;

  assign tick     = (pre == PRE_LAST);
  assign boundary = tick && (dig == 3'd7);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dig <= '0;
    end else if (tick) begin
      dig <= dig + 3'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame snapshot
  // ---------------------------------------------------------------------------
  logic [31:0] snap;
  logic [31:0] snap_src;

  always_comb begin
    snap_src = '0;
    unique case (view)
      VIEW_PC:    snap_src = pc;
      VIEW_INST:  snap_src = inst;
      VIEW_ALU:   snap_src = aluout;
      VIEW_MEM:   snap_src = memout;
      VIEW_REG,
      VIEW_AUTO:  snap_src = reg_out;
      VIEW_ZERO0,
      VIEW_ZERO1: snap_src = '0;
      default:    snap_src = '0;
    endcase
  end

  // reg_out still reflects the pre-step reg_addr at a boundary, so a step
  // taken on the same edge first becomes visible one frame later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      snap <= '0;
    end else if (boundary) begin
      snap <= snap_src;
    end
  end

  // ---------------------------------------------------------------------------
  // Register index: manual stepping (view 4) and auto-scan (view 5)
  // ---------------------------------------------------------------------------
  logic [FW-1:0] frame_cnt;
  logic [FW-1:0] frame_nxt;
  logic          addr_step;

  // The two step sources live in different views, so at most one fires.
  always_comb begin
    frame_nxt = frame_cnt;
    addr_step = 1'b0;
    if (view != VIEW_AUTO) begin
      frame_nxt = '0;
    end else if (boundary) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_nxt = '0;
        addr_step = 1'b1;
      end else begin
        frame_nxt = frame_cnt + 1'b1;
      end
    end
    if ((view == VIEW_REG) && btn_next) begin
      addr_step = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
    end else begin
      frame_cnt <= frame_nxt;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reg_addr <= '0;
    end else if (addr_step) begin
      reg_addr <= reg_addr + 5'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Digit decode and registered outputs
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] hex_glyph(input logic [3:0] h);
    logic [6:0] g;
    unique case (h)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      4'hF: g = 7'h0E;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  logic [3:0] nibble;
  logic       dp_on;
  logic [7:0] an_nxt;
  logic [7:0] seg_nxt;

  always_comb begin
    nibble  = snap[{dig, 2'b00} +: 4];
    dp_on   = ((view == VIEW_REG) || (view == VIEW_AUTO)) && (dig == 3'd7);
    an_nxt  = ~(8'd1 << dig);
    seg_nxt = {~dp_on, hex_glyph(nibble)};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      an  <= '1;
      seg <= '1;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_sccomp_debug_display.sv
// -----------------------------------------------------------------------------
// tb_sccomp_debug_display
//
// Two instances share stimulus: u_scan (SCAN_DIV=4, AUTO_FRAMES=3) and
// u_auto (SCAN_DIV=2, AUTO_FRAMES=2). Each has its own reg_out, modelled as
// {27'h0, reg_addr} + 32'h1000. A reference model computes expected outputs
// from the number of clock edges since reset release.
// -----------------------------------------------------------------------------
module tb_sccomp_debug_display;

  localparam int unsigned DIV0 = 4;
  localparam int unsigned FR0  = 3;
  localparam int unsigned DIV1 = 2;
  localparam int unsigned FR1  = 2;

  logic        clock;
  logic        reset;
  logic [2:0]  sel;
  logic        btn_next;
  logic [31:0] pc, inst, aluout, memout;
  logic [31:0] reg_out0, reg_out1;
  logic [4:0]  addr0, addr1;
  logic [7:0]  an0, an1, seg0, seg1;

  int unsigned tests_run;
  int unsigned tests_failed;

  function automatic logic [31:0] reg_model(input logic [4:0] a);
    return {27'h0, a} + 32'h1000;
  endfunction

  assign reg_out0 = reg_model(addr0);
  assign reg_out1 = reg_model(addr1);

  sccomp_debug_display #(.SCAN_DIV(DIV0), .AUTO_FRAMES(FR0)) u_scan (
    .clock(clock), .reset(reset), .sel(sel), .btn_next(btn_next),
    .pc(pc), .inst(inst), .aluout(aluout), .memout(memout),
    .reg_out(reg_out0), .reg_addr(addr0), .an(an0), .seg(seg0)
  );

  sccomp_debug_display #(.SCAN_DIV(DIV1), .AUTO_FRAMES(FR1)) u_auto (
    .clock(clock), .reset(reset), .sel(sel), .btn_next(btn_next),
    .pc(pc), .inst(inst), .aluout(aluout), .memout(memout),
    .reg_out(reg_out1), .reg_addr(addr1), .an(an1), .seg(seg1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int unsigned n_edges [2];
  int unsigned m_frames[2];
  logic [4:0]  m_addr  [2];
  logic [31:0] m_snap  [2];
  logic [7:0]  m_an    [2];
  logic [7:0]  m_seg   [2];

  function automatic logic [6:0] glyph_of(input logic [3:0] h);
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[h];
  endfunction

  function automatic int unsigned div_of(input int i);
    return (i == 0) ? DIV0 : DIV1;
  endfunction

  function automatic int unsigned fr_of(input int i);
    return (i == 0) ? FR0 : FR1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      n_edges[i]  = 0;
      m_frames[i] = 0;
      m_addr[i]   = '0;
      m_snap[i]   = '0;
      m_an[i]     = 8'hFF;
      m_seg[i]    = 8'hFF;
    end
  endtask

  // Advance the model across one rising edge using the inputs seen there.
  task automatic model_step();
    if (reset) return;
    for (int i = 0; i < 2; i++) begin
      int unsigned d;
      int unsigned digit;
      logic [31:0] shifted;
      logic [31:0] pick;
      d       = div_of(i);
      digit   = (n_edges[i] / d) % 8;
      shifted = m_snap[i] >> (4 * digit);
      m_an[i]  = ~(8'd1 << digit);
      m_seg[i] = {!(((sel == 3'd4) || (sel == 3'd5)) && (digit == 7)),
                  glyph_of(shifted[3:0])};
      if ((n_edges[i] % (8 * d)) == (8 * d - 1)) begin
        case (sel)
          3'd0:       pick = pc;
          3'd1:       pick = inst;
          3'd2:       pick = aluout;
          3'd3:       pick = memout;
          3'd4, 3'd5: pick = reg_model(m_addr[i]);
          default:    pick = 32'h0;
        endcase
        m_snap[i] = pick;
        if (sel == 3'd5) begin
          m_frames[i]++;
          if (m_frames[i] == fr_of(i)) begin
            m_frames[i] = 0;
            m_addr[i]++;
          end
        end
      end
      if (sel != 3'd5) m_frames[i] = 0;
      if ((sel == 3'd4) && btn_next) m_addr[i]++;
      n_edges[i]++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    check_eq("an0",   {24'h0, an0},   {24'h0, m_an[0]});
    check_eq("seg0",  {24'h0, seg0},  {24'h0, m_seg[0]});
    check_eq("addr0", {27'h0, addr0}, {27'h0, m_addr[0]});
    check_eq("an1",   {24'h0, an1},   {24'h0, m_an[1]});
    check_eq("seg1",  {24'h0, seg1},  {24'h0, m_seg[1]});
    check_eq("addr1", {27'h0, addr1}, {27'h0, m_addr[1]});
  endtask

  // One clock: model follows the rising edge, outputs compared at the
  // falling edge; callers drive inputs after this returns.
  task automatic run_cycle();
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare_all();
  endtask

  task automatic run_cycles(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) run_cycle();
  endtask

  task automatic pulse_btn();
    btn_next = 1'b1;
    run_cycle();
    btn_next = 1'b0;
    run_cycle();
  endtask

  // Run until u_scan shows the given digit enable, then check its segments.
  task automatic expect_digit0(input string tag, input logic [7:0] an_want,
                               input logic [7:0] seg_want);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      run_cycle();
      if (an0 == an_want) found = 1'b1;
    end
    if (found) check_eq(tag, {24'h0, seg0}, {24'h0, seg_want});
    else       check_eq({tag, "_timeout"}, {24'h0, an0}, {24'h0, an_want});
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    bit found;
    tests_run    = 0;
    tests_failed = 0;
    reset    = 1'b1;
    sel      = 3'd6;
    btn_next = 1'b0;
    pc       = '0;
    inst     = '0;
    aluout   = '0;
    memout   = '0;
    model_reset();

    // Reset and idle
    run_cycles(3);
    check_eq("an_in_reset", {24'h0, an0}, 32'hFF);
    reset = 1'b0;
    run_cycle();
    check_eq("first_an",  {24'h0, an0},  32'hFE);
    check_eq("first_seg", {24'h0, seg0}, 32'hC0);
    run_cycles(36);

    // View 0 capture
    pc  = 32'h0040_00A4;
    sel = 3'd0;
    run_cycles(66);
    expect_digit0("pc_digit1", 8'hFD, 8'h88);
    expect_digit0("pc_digit0", 8'hFE, 8'h99);

    // Manual register view
    sel = 3'd4;
    for (int k = 0; k < 3; k++) pulse_btn();
    check_eq("manual_addr", {27'h0, addr0}, 32'd3);
    run_cycles(70);
    expect_digit0("reg_digit7_dp", 8'h7F, 8'h40);
    expect_digit0("reg_digit0",    8'hFE, 8'hB0);

    // Register wrap, then a pulse outside view 4
    for (int k = 0; k < 32; k++) pulse_btn();
    check_eq("wrap_addr", {27'h0, addr0}, 32'd3);
    sel = 3'd0;
    pulse_btn();
    check_eq("btn_ignored", {27'h0, addr0}, 32'd3);

    // Auto-scan
    sel = 3'd5;
    run_cycles(330);

    // Randomised views, pulses and data
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 99) < 3) sel = 3'($urandom_range(0, 7));
      btn_next = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) pc     = $urandom;
      if ($urandom_range(0, 9) == 0) inst   = $urandom;
      if ($urandom_range(0, 9) == 0) aluout = $urandom;
      if ($urandom_range(0, 9) == 0) memout = $urandom;
      run_cycle();
    end
    btn_next = 1'b0;

    // Asynchronous reset mid-frame with dig=5 and reg_addr=7
    sel = 3'd4;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (m_addr[0] == 5'd7) found = 1'b1;
      else pulse_btn();
    end
    check_eq("reach_addr7", {27'h0, addr0}, 32'd7);
    sel = 3'd6;
    found = 1'b0;
    for (int k = 0; k < 64 && !found; k++) begin
      run_cycle();
      if (((n_edges[0] / DIV0) % 8) == 5) found = 1'b1;
    end
    check_eq("reach_dig5", {31'h0, found}, 32'd1);
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    check_eq("async_an",   {24'h0, an0},   32'hFF);
    check_eq("async_seg",  {24'h0, seg0},  32'hFF);
    check_eq("async_addr", {27'h0, addr0}, 32'd0);
    run_cycles(2);
    reset = 1'b0;
    run_cycles(40);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
